// File: rtl/seq_detector_pkg.sv
// rtl/seq_detector_pkg.sv - shared FSM state type and default widths for the sequence detector
package seq_detector_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_PAT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_window_cmp.sv
// rtl/seq_window_cmp.sv - sliding bit window with fill tracking and masked pattern compare
module seq_window_cmp
    import seq_detector_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear_i,
    input  logic             shift_i,
    input  logic             bit_i,
    input  logic             overlap_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [PAT_W-1:0] mask_i,
    output logic             hit_o
);

    localparam int                FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  next_hist;
    logic [FILL_W-1:0] fill_next;

    // Window update and compare against the window as it will look after this bit
    always_comb begin
        next_hist = (hist_q << 1) | PAT_W'(bit_i);
        fill_next = (fill_q == FULL) ? FULL : fill_q + 1'b1;
        hit_o     = shift_i && (fill_next == FULL)
                    && (((next_hist ^ pattern_i) & mask_i) == '0);
        hist_d    = hist_q;
        fill_d    = fill_q;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_i) begin
            hist_d = next_hist;
            // Non-overlapping mode forgets the matched bits by emptying the window
            fill_d = (hit_o && !overlap_i) ? '0 : fill_next;
        end
    end

    // Window registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - serial MSB-first sequence detector; SEQDET_MASK_EN adds pat_mask_i don't-care mask
module seq_detector_param
    import seq_detector_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int PAT_W  = DEF_PAT_W,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [PAT_W-1:0]  pattern_i,
`ifdef SEQDET_MASK_EN
    input  logic [PAT_W-1:0]  pat_mask_i,
`endif
    input  logic              overlap_i,
    output logic              busy_o,
    output logic              match_o,
    output logic [CNT_W-1:0]  match_cnt_o,
    output logic              found_o,
    output logic              done_o
);

    localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-1:0]  mask_q, mask_d;
    logic              ovl_q, ovl_d;
    logic              match_q, match_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              found_q, found_d;
    logic [PAT_W-1:0]  mask_in;
    logic              clear, shift, hit;

`ifdef SEQDET_MASK_EN
    assign mask_in = pat_mask_i;
`else
    assign mask_in = '1;
`endif

    seq_window_cmp #(
        .PAT_W (PAT_W)
    ) u_window (
        .clk       (clk),
        .rstn      (rstn),
        .clear_i   (clear),
        .shift_i   (shift),
        .bit_i     (data_q[idx_q]),
        .overlap_i (ovl_q),
        .pattern_i (pat_q),
        .mask_i    (mask_q),
        .hit_o     (hit)
    );

    // Next-state logic: start always wins and restarts from any state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        pat_d   = pat_q;
        mask_d  = mask_q;
        ovl_d   = ovl_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
        found_d = found_q;
        clear   = 1'b0;
        shift   = 1'b0;
        if (start_i) begin
            state_d = SCAN;
            idx_d   = IDX_LAST;
            data_d  = data_i;
            pat_d   = pattern_i;
            mask_d  = mask_in;
            ovl_d   = overlap_i;
            cnt_d   = '0;
            found_d = 1'b0;
            clear   = 1'b1;
        end else begin
            case (state_q)
                SCAN: begin
                    shift = 1'b1;
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        found_d = 1'b1;
                    end
                    if (idx_q == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers, all cleared asynchronously
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            pat_q   <= '0;
            mask_q  <= '0;
            ovl_q   <= 1'b0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            ovl_q   <= ovl_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            found_q <= found_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign match_o     = match_q;
    assign match_cnt_o = cnt_q;
    assign found_o     = found_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - self-checking bench for seq_detector_param over four width configurations
module tb_seq_detector_param;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_v = 1'b0;
    logic [15:0] data_v = '0;
    logic [4:0]  pattern_v = '0;
    logic [4:0]  mask_v = '1;
    logic        ovl_v = 1'b0;
    int          sel = 0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    logic       busy_a, match_a, found_a, done_a;
    logic [3:0] cnt_a;
    logic       busy_b, match_b, found_b, done_b;
    logic [4:0] cnt_b;
    logic       busy_c, match_c, found_c, done_c;
    logic [2:0] cnt_c;
    logic       busy_d, match_d, found_d, done_d;
    logic [2:0] cnt_d;

    logic       busy_v, match_v, found_v, done_v;
    logic [4:0] cnt_v;

    seq_detector_param u_a (
        .clk (clk), .rstn (rstn), .start_i (start_v && sel == 0),
        .data_i (data_v[7:0]), .pattern_i (pattern_v[4:0]),
`ifdef SEQDET_MASK_EN
        .pat_mask_i (mask_v[4:0]),
`endif
        .overlap_i (ovl_v), .busy_o (busy_a), .match_o (match_a),
        .match_cnt_o (cnt_a), .found_o (found_a), .done_o (done_a)
    );

    seq_detector_param #(.DATA_W (16), .PAT_W (4)) u_b (
        .clk (clk), .rstn (rstn), .start_i (start_v && sel == 1),
        .data_i (data_v), .pattern_i (pattern_v[3:0]),
`ifdef SEQDET_MASK_EN
        .pat_mask_i (mask_v[3:0]),
`endif
        .overlap_i (ovl_v), .busy_o (busy_b), .match_o (match_b),
        .match_cnt_o (cnt_b), .found_o (found_b), .done_o (done_b)
    );

    seq_detector_param #(.DATA_W (4), .PAT_W (4)) u_c (
        .clk (clk), .rstn (rstn), .start_i (start_v && sel == 2),
        .data_i (data_v[3:0]), .pattern_i (pattern_v[3:0]),
`ifdef SEQDET_MASK_EN
        .pat_mask_i (mask_v[3:0]),
`endif
        .overlap_i (ovl_v), .busy_o (busy_c), .match_o (match_c),
        .match_cnt_o (cnt_c), .found_o (found_c), .done_o (done_c)
    );

    seq_detector_param #(.DATA_W (6), .PAT_W (1)) u_d (
        .clk (clk), .rstn (rstn), .start_i (start_v && sel == 3),
        .data_i (data_v[5:0]), .pattern_i (pattern_v[0:0]),
`ifdef SEQDET_MASK_EN
        .pat_mask_i (mask_v[0:0]),
`endif
        .overlap_i (ovl_v), .busy_o (busy_d), .match_o (match_d),
        .match_cnt_o (cnt_d), .found_o (found_d), .done_o (done_d)
    );

    always_comb begin
        busy_v = busy_a; match_v = match_a; found_v = found_a; done_v = done_a; cnt_v = 5'(cnt_a);
        case (sel)
            1: begin busy_v = busy_b; match_v = match_b; found_v = found_b; done_v = done_b; cnt_v = cnt_b; end
            2: begin busy_v = busy_c; match_v = match_c; found_v = found_c; done_v = done_c; cnt_v = 5'(cnt_c); end
            3: begin busy_v = busy_d; match_v = match_d; found_v = found_d; done_v = done_d; cnt_v = 5'(cnt_d); end
            default: ;
        endcase
    end

    function automatic int dw_of(input int s);
        case (s)
            1: return 16;
            2: return 4;
            3: return 6;
            default: return 8;
        endcase
    endfunction

    function automatic int pw_of(input int s);
        case (s)
            1: return 4;
            2: return 4;
            3: return 1;
            default: return 5;
        endcase
    endfunction

    // Reference: bit e of the result is set when the occurrence ending at the e-th scanned bit counts
    function automatic logic [16:0] model(input logic [15:0] d, input logic [4:0] p, input logic [4:0] m,
                                          input bit ov, input int dw, input int pw);
        logic [16:0] h = '0;
        int          bound = 0;
        bit          ok;
        for (int e = pw; e <= dw; e++) begin
            if (e - pw >= bound) begin
                ok = 1'b1;
                for (int j = 0; j < pw; j++)
                    if (m[pw-1-j] && (d[dw-1-(e-pw+j)] != p[pw-1-j])) ok = 1'b0;
                if (ok) begin
                    h[e] = 1'b1;
                    if (!ov) bound = e;
                end
            end
        end
        return h;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (sel=%0d t=%0t): got %0d expected %0d", nm, sel, $time, act, exp);
        end
    endtask

    function automatic logic [4:0] eff_mask(input logic [4:0] m);
`ifdef SEQDET_MASK_EN
        return m;
`else
        return 5'h1F | m;
`endif
    endfunction

    task automatic start_scan(input logic [15:0] d, input logic [4:0] p, input logic [4:0] m, input bit ov);
        @(negedge clk);
        data_v = d; pattern_v = p; mask_v = m; ovl_v = ov; start_v = 1'b1;
        @(posedge clk);
        #1 start_v = 1'b0;
    endtask

    // Checks every cycle from the one after the start edge through the first idle cycle
    task automatic follow_scan(input logic [15:0] d, input logic [4:0] p, input logic [4:0] m,
                               input bit ov, output int final_cnt);
        logic [16:0] h;
        int          dw, run;
        bit          f, em;
        dw  = dw_of(sel);
        h   = model(d, p, m, ov, dw, pw_of(sel));
        run = 0;
        f   = 1'b0;
        for (int k = 0; k <= dw; k++) begin
            @(negedge clk);
            em = (k >= 1) && h[k];
            if (em) begin run++; f = 1'b1; end
            chk("match_o", int'(match_v), int'(em));
            chk("done_o", int'(done_v), (k == dw) ? 1 : 0);
            chk("busy_o", int'(busy_v), 1);
            chk("match_cnt_o", int'(cnt_v), run);
            chk("found_o", int'(found_v), int'(f));
        end
        @(negedge clk);
        chk("idle_busy", int'(busy_v), 0);
        chk("idle_done", int'(done_v), 0);
        chk("idle_match", int'(match_v), 0);
        chk("idle_cnt_hold", int'(cnt_v), run);
        chk("idle_found_hold", int'(found_v), int'(f));
        final_cnt = run;
    endtask

    typedef struct {
        int          s;
        logic [15:0] d;
        logic [4:0]  p;
        logic [4:0]  m;
        bit          ov;
        int          exp_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic restart_case(input int s, input logic [15:0] d1, input logic [15:0] d2, input logic [4:0] p);
        int c;
        sel = s;
        start_scan(d1, p, 5'h1F, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("pre_restart_done", int'(done_v), 0);
            chk("pre_restart_busy", int'(busy_v), 1);
        end
        start_scan(d2, p, 5'h1F, 1'b1);
        follow_scan(d2, p, 5'h1F, 1'b1, c);
    endtask

    initial begin
        int c;
        logic [15:0] rd;
        logic [4:0]  rp, rm;
        bit          rov;
        int          dw, pw;

        tbl.push_back('{0, 16'h0092, 5'b10010, 5'h1F, 1'b1, 2});
        tbl.push_back('{0, 16'h0092, 5'b10010, 5'h1F, 1'b0, 1});
        tbl.push_back('{0, 16'h0000, 5'b10010, 5'h1F, 1'b1, 0});
        tbl.push_back('{0, 16'h0012, 5'b10010, 5'h1F, 1'b1, 1});
        tbl.push_back('{0, 16'h00FF, 5'b11111, 5'h1F, 1'b1, 4});
        tbl.push_back('{0, 16'h00FF, 5'b11111, 5'h1F, 1'b0, 1});
        tbl.push_back('{1, 16'hFFFF, 5'b01111, 5'h1F, 1'b1, 13});
        tbl.push_back('{1, 16'hFFFF, 5'b01111, 5'h1F, 1'b0, 4});
        tbl.push_back('{2, 16'h000B, 5'b01011, 5'h1F, 1'b1, 1});
        tbl.push_back('{2, 16'h000B, 5'b01010, 5'h1F, 1'b1, 0});
        tbl.push_back('{2, 16'h000F, 5'b01111, 5'h1F, 1'b0, 1});
        tbl.push_back('{3, 16'h002D, 5'b00001, 5'h1F, 1'b1, 4});
        tbl.push_back('{3, 16'h002D, 5'b00001, 5'h1F, 1'b0, 4});
        tbl.push_back('{3, 16'h002D, 5'b00000, 5'h1F, 1'b1, 2});
`ifdef SEQDET_MASK_EN
        tbl.push_back('{0, 16'h00B0, 5'b10010, 5'b11011, 1'b1, 1});
`endif

        // Reset values on every configuration
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            chk("rst_busy", int'(busy_v), 0);
            chk("rst_match", int'(match_v), 0);
            chk("rst_cnt", int'(cnt_v), 0);
            chk("rst_found", int'(found_v), 0);
            chk("rst_done", int'(done_v), 0);
        end
        @(negedge clk);
        rstn = 1'b1;

        // Directed vectors
        foreach (tbl[i]) begin
            sel = tbl[i].s;
            start_scan(tbl[i].d, tbl[i].p, eff_mask(tbl[i].m), tbl[i].ov);
            follow_scan(tbl[i].d, tbl[i].p, eff_mask(tbl[i].m), tbl[i].ov, c);
            chk("table_cnt", int'(cnt_v), tbl[i].exp_cnt);
        end

        // Restart mid-scan: counters cleared, only the second scan reports done
        restart_case(0, 16'h0092, 16'h0012, 5'b10010);
        restart_case(3, 16'h003F, 16'h0021, 5'b00001);

        // Asynchronous reset in the middle of a scan
        sel = 0;
        start_scan(16'h00FF, 5'b11111, 5'h1F, 1'b1);
        repeat (6) @(posedge clk);
        #2;
        chk("pre_rst_cnt", int'(cnt_v), 2);
        rstn = 1'b0;
        #1;
        chk("arst_busy", int'(busy_v), 0);
        chk("arst_match", int'(match_v), 0);
        chk("arst_cnt", int'(cnt_v), 0);
        chk("arst_found", int'(found_v), 0);
        chk("arst_done", int'(done_v), 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_idle", int'(busy_v), 0);
            chk("post_rst_done", int'(done_v), 0);
        end

        // Randomized scans against the reference model
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 3));
            dw  = dw_of(sel);
            pw  = pw_of(sel);
            rd  = 16'($urandom);
            rov = 1'($urandom);
            rm  = eff_mask(5'($urandom));
            if ($urandom_range(0, 1) == 0)
                rp = 5'(rd >> $urandom_range(0, dw - pw));
            else
                rp = 5'($urandom);
            start_scan(rd, rp, rm, rov);
            follow_scan(rd, rp, rm, rov, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
